trap_ctrl: RTL and testbench

- Multi-cycle trap and CSR-access sequencer that sits directly upstream of the CSR register file.
- Takes decoded ecall, mret and CSR-instruction requests from the decode stage.
- Drives the CSR file's read and write ports and its `ecall_en`/`ecall_NO` trap inputs.
- Stalls the fetch stage while a sequence runs, then issues a one-cycle PC redirect to mtvec or mepc.

---
 rtl/trap_ctrl_pkg.sv | 28 ++
 rtl/trap_ctrl_if.sv | 47 ++++
 rtl/trap_ctrl_csr_alu.sv | 22 ++
 rtl/trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_trap_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap/CSR-access sequencer.
// Addresses are the machine-mode CSRs this block touches or is tested against.
package trap_ctrl_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CSR_AW    = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    CSR_OP_RW  = 2'b00,
    CSR_OP_RS  = 2'b01,
    CSR_OP_RC  = 2'b10,
    CSR_OP_RSV = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CSR_RD   = 3'd1,
    ST_CSR_WB   = 3'd2,
    ST_TRAP     = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between decode/CSR file (master side) and the trap sequencer (slave side).
interface trap_ctrl_if #(
  parameter int CPU_WIDTH = trap_ctrl_pkg::CPU_WIDTH,
  parameter int CSR_AW    = trap_ctrl_pkg::CSR_AW
);

  logic                 inst_valid;
  logic                 is_ecall;
  logic                 is_mret;
  logic                 is_csr;
  logic [1:0]           csr_op;
  logic                 rs1_zero;
  logic [CSR_AW-1:0]    csr_addr;
  logic [CPU_WIDTH-1:0] rs1_data;
  logic [CPU_WIDTH-1:0] pc;
  logic [7:0]           a7;
  logic [CPU_WIDTH-1:0] mtvec;
  logic [CPU_WIDTH-1:0] mepc;
  logic [CPU_WIDTH-1:0] csr_rdata;

  logic [CSR_AW-1:0]    csr_raddr;
  logic                 csr_wen;
  logic [CSR_AW-1:0]    csr_waddr;
  logic [CPU_WIDTH-1:0] csr_wdata;
  logic                 ecall_en;
  logic [7:0]           ecall_no;
  logic                 rd_wen;
  logic [CPU_WIDTH-1:0] rd_wdata;
  logic                 stall;
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_pc;

  modport master (
    output inst_valid, is_ecall, is_mret, is_csr, csr_op, rs1_zero, csr_addr,
           rs1_data, pc, a7, mtvec, mepc, csr_rdata,
    input  csr_raddr, csr_wen, csr_waddr, csr_wdata, ecall_en, ecall_no,
           rd_wen, rd_wdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, is_ecall, is_mret, is_csr, csr_op, rs1_zero, csr_addr,
           rs1_data, pc, a7, mtvec, mepc, csr_rdata,
    output csr_raddr, csr_wen, csr_waddr, csr_wdata, ecall_en, ecall_no,
           rd_wen, rd_wdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_ctrl_csr_alu.sv
// Read-modify-write value for csrrw/csrrs/csrrc; the reserved op behaves as rw.
module trap_ctrl_csr_alu
  import trap_ctrl_pkg::*;
#(
  parameter int WIDTH = trap_ctrl_pkg::CPU_WIDTH
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] rs1,
  input  csr_op_e          op,
  output logic [WIDTH-1:0] new_val
);

  always_comb begin
    new_val = rs1;
    case (op)
      CSR_OP_RS: new_val = old_val | rs1;
      CSR_OP_RC: new_val = old_val & ~rs1;
      default:   new_val = rs1;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap and CSR-access sequencer: stalls fetch, drives the CSR file ports and
// issues a one-cycle redirect to mtvec (ecall) or mepc (mret).
//
//   state       | meaning
//   ST_IDLE     | waiting for ecall/mret/csr from decode
//   ST_CSR_RD   | CSR read address driven, old value captured
//   ST_CSR_WB   | old value to rd, new value to CSR file
//   ST_TRAP     | ecall_en strobe with latched pc/a7, mtvec captured
//   ST_REDIRECT | redirect strobe to latched target
module trap_ctrl #(
  parameter int CPU_WIDTH = trap_ctrl_pkg::CPU_WIDTH,
  parameter int CSR_AW    = trap_ctrl_pkg::CSR_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  trap_ctrl_if.slave bus
);

  import trap_ctrl_pkg::*;

  state_e               state;
  logic [CPU_WIDTH-1:0] pc_q;
  logic [CPU_WIDTH-1:0] rs1_q;
  logic [CPU_WIDTH-1:0] old_q;
  logic [CPU_WIDTH-1:0] target_q;
  logic [7:0]           a7_q;
  logic [CSR_AW-1:0]    addr_q;
  csr_op_e              op_q;
  logic                 rs1_zero_q;

  logic                 accept;
  logic [CPU_WIDTH-1:0] alu_new;

  assign accept = (state == ST_IDLE) && bus.inst_valid &&
                  (bus.is_ecall || bus.is_mret || bus.is_csr);

  trap_ctrl_csr_alu #(.WIDTH(CPU_WIDTH)) u_csr_alu (
    .old_val (old_q),
    .rs1     (rs1_q),
    .op      (op_q),
    .new_val (alu_new)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc_q       <= '0;
      rs1_q      <= '0;
      old_q      <= '0;
      target_q   <= '0;
      a7_q       <= '0;
      addr_q     <= '0;
      op_q       <= CSR_OP_RW;
      rs1_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pc_q       <= bus.pc;
            a7_q       <= bus.a7;
            addr_q     <= bus.csr_addr;
            op_q       <= csr_op_e'(bus.csr_op);
            rs1_q      <= bus.rs1_data;
            rs1_zero_q <= bus.rs1_zero;
            if (bus.is_ecall) begin
              state <= ST_TRAP;
            end else if (bus.is_mret) begin
              target_q <= bus.mepc;
              state    <= ST_REDIRECT;
            end else begin
              state <= ST_CSR_RD;
            end
          end
        end
        ST_TRAP: begin
          // The trap write only touches mepc/mcause, so mtvec is stable here.
          target_q <= bus.mtvec;
          state    <= ST_REDIRECT;
        end
        ST_REDIRECT: state <= ST_IDLE;
        ST_CSR_RD: begin
          old_q <= bus.csr_rdata;
          state <= ST_CSR_WB;
        end
        ST_CSR_WB: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  logic [CSR_AW-1:0]    raddr_d;
  logic                 csr_wen_d;
  logic [CSR_AW-1:0]    waddr_d;
  logic [CPU_WIDTH-1:0] wdata_d;
  logic                 ecall_en_d;
  logic [7:0]           ecall_no_d;
  logic                 rd_wen_d;
  logic [CPU_WIDTH-1:0] rd_wdata_d;
  logic                 redir_d;
  logic [CPU_WIDTH-1:0] redir_pc_d;

  // Strobes carry rst_n so a sequence caught by reset leaves no side effects.
  always_comb begin
    raddr_d    = '0;
    csr_wen_d  = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    ecall_en_d = 1'b0;
    ecall_no_d = '0;
    rd_wen_d   = 1'b0;
    rd_wdata_d = '0;
    redir_d    = 1'b0;
    redir_pc_d = '0;
    case (state)
      ST_TRAP: begin
        ecall_en_d = rst_n;
        wdata_d    = pc_q;
        ecall_no_d = a7_q;
      end
      ST_REDIRECT: begin
        redir_d    = rst_n;
        redir_pc_d = target_q;
      end
      ST_CSR_RD: raddr_d = addr_q;
      ST_CSR_WB: begin
        rd_wen_d   = rst_n;
        rd_wdata_d = old_q;
        waddr_d    = addr_q;
        wdata_d    = alu_new;
        csr_wen_d  = rst_n &&
                     !(((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC)) && rs1_zero_q);
      end
      default: ;
    endcase
  end

  assign bus.csr_raddr      = raddr_d;
  assign bus.csr_wen        = csr_wen_d;
  assign bus.csr_waddr      = waddr_d;
  assign bus.csr_wdata      = wdata_d;
  assign bus.ecall_en       = ecall_en_d;
  assign bus.ecall_no       = ecall_no_d;
  assign bus.rd_wen         = rd_wen_d;
  assign bus.rd_wdata       = rd_wdata_d;
  assign bus.stall          = (state != ST_IDLE) || accept;
  assign bus.redirect_valid = redir_d;
  assign bus.redirect_pc    = redir_pc_d;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a behavioural CSR file and a transaction-level reference
// that predicts each sequence's cycle-by-cycle effects from the instruction rules.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  trap_ctrl_if bus ();

  trap_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file seen by the DUT, updated only by DUT strobes or bench preloads.
  bit [31:0] csr_file [4096];
  // Reference CSR state, updated only from the bench's own expectations.
  bit [31:0] ref_csr  [4096];
  logic        pre_wen;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (bus.csr_wen) csr_file[bus.csr_waddr] <= bus.csr_wdata;
    if (bus.ecall_en) begin
      csr_file[CSR_MEPC]   <= bus.csr_wdata;
      csr_file[CSR_MCAUSE] <= {24'b0, bus.ecall_no};
    end
    if (pre_wen) csr_file[pre_addr] <= pre_data;
  end

  always_comb begin
    bus.csr_rdata = csr_file[bus.csr_raddr];
    bus.mtvec     = csr_file[CSR_MTVEC];
    bus.mepc      = csr_file[CSR_MEPC];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    pre_wen  = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_csr[a] = d;
    @(negedge clk);
    pre_wen = 1'b0;
  endtask

  task automatic scramble();
    bus.pc       = $urandom;
    bus.a7       = 8'($urandom);
    bus.csr_addr = 12'($urandom);
    bus.rs1_data = $urandom;
    bus.rs1_zero = 1'($urandom);
    bus.csr_op   = 2'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check_eq({tag, "_strobes"},
             32'({bus.csr_wen, bus.ecall_en, bus.rd_wen, bus.redirect_valid}), 32'd0);
    check_eq({tag, "_raddr"}, 32'(bus.csr_raddr), 32'd0);
    check_eq({tag, "_redir_pc"}, bus.redirect_pc, 32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.inst_valid = 1'b0;
    bus.is_ecall   = 1'($urandom);
    bus.is_mret    = 1'($urandom);
    bus.is_csr     = 1'($urandom);
    scramble();
    #1;
    check_idle("idle");
  endtask

  task automatic do_inst(input bit e, input bit m, input bit c, input logic [1:0] op,
                         input bit rz, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [31:0] pcv, input logic [7:0] a7v);
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [31:0] tgt;
    bit          wen;
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.is_ecall   = e;
    bus.is_mret    = m;
    bus.is_csr     = c;
    bus.csr_op     = op;
    bus.rs1_zero   = rz;
    bus.csr_addr   = addr;
    bus.rs1_data   = rs1;
    bus.pc         = pcv;
    bus.a7         = a7v;
    #1;
    check_eq("acc_stall", 32'(bus.stall), 32'd1);
    check_eq("acc_strobes",
             32'({bus.csr_wen, bus.ecall_en, bus.rd_wen, bus.redirect_valid}), 32'd0);
    if (e) begin
      @(negedge clk); scramble(); #1;
      check_eq("trap_ecall_en", 32'(bus.ecall_en), 32'd1);
      check_eq("trap_wdata", bus.csr_wdata, pcv);
      check_eq("trap_no", 32'(bus.ecall_no), 32'(a7v));
      check_eq("trap_csr_wen", 32'(bus.csr_wen), 32'd0);
      check_eq("trap_raddr", 32'(bus.csr_raddr), 32'd0);
      check_eq("trap_redir", 32'(bus.redirect_valid), 32'd0);
      check_eq("trap_stall", 32'(bus.stall), 32'd1);
      tgt = ref_csr[CSR_MTVEC];
      ref_csr[CSR_MEPC]   = pcv;
      ref_csr[CSR_MCAUSE] = {24'b0, a7v};
      @(negedge clk); scramble(); #1;
      check_eq("ecall_redir", 32'(bus.redirect_valid), 32'd1);
      check_eq("ecall_redir_pc", bus.redirect_pc, tgt);
      check_eq("ecall_redir_en", 32'(bus.ecall_en), 32'd0);
      check_eq("ecall_redir_stall", 32'(bus.stall), 32'd1);
    end else if (m) begin
      tgt = ref_csr[CSR_MEPC];
      @(negedge clk); scramble(); #1;
      check_eq("mret_redir", 32'(bus.redirect_valid), 32'd1);
      check_eq("mret_redir_pc", bus.redirect_pc, tgt);
      check_eq("mret_no_write", 32'({bus.csr_wen, bus.ecall_en, bus.rd_wen}), 32'd0);
      check_eq("mret_stall", 32'(bus.stall), 32'd1);
    end else begin
      old_v = ref_csr[addr];
      case (op)
        2'b01:   new_v = old_v | rs1;
        2'b10:   new_v = old_v & ~rs1;
        default: new_v = rs1;
      endcase
      wen = !((op == 2'b01 || op == 2'b10) && rz);
      @(negedge clk); scramble(); #1;
      check_eq("rd_raddr", 32'(bus.csr_raddr), 32'(addr));
      check_eq("rd_strobes", 32'({bus.csr_wen, bus.rd_wen, bus.ecall_en}), 32'd0);
      check_eq("rd_stall", 32'(bus.stall), 32'd1);
      @(negedge clk); scramble(); #1;
      check_eq("wb_rd_wen", 32'(bus.rd_wen), 32'd1);
      check_eq("wb_rd_wdata", bus.rd_wdata, old_v);
      check_eq("wb_waddr", 32'(bus.csr_waddr), 32'(addr));
      check_eq("wb_csr_wen", 32'(bus.csr_wen), 32'(wen));
      if (wen) check_eq("wb_wdata", bus.csr_wdata, new_v);
      check_eq("wb_stall", 32'(bus.stall), 32'd1);
      if (wen) ref_csr[addr] = new_v;
    end
  endtask

  localparam int N_ADDR = 5;
  logic [11:0] addr_list [N_ADDR];

  initial begin
    bit          e, m, c, rz;
    logic [31:0] rs1;
    n_checks = 0;
    n_errors = 0;
    addr_list[0] = CSR_MSTATUS;
    addr_list[1] = CSR_MTVEC;
    addr_list[2] = CSR_MEPC;
    addr_list[3] = CSR_MCAUSE;
    addr_list[4] = 12'h340;
    pre_wen = 1'b0; pre_addr = '0; pre_data = '0;
    bus.inst_valid = 1'b0; bus.is_ecall = 1'b0; bus.is_mret = 1'b0; bus.is_csr = 1'b0;
    bus.csr_op = '0; bus.rs1_zero = 1'b0; bus.csr_addr = '0; bus.rs1_data = '0;
    bus.pc = '0; bus.a7 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_strobes",
             32'({bus.csr_wen, bus.ecall_en, bus.rd_wen, bus.redirect_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("post_rst");

    // ecall
    set_csr(CSR_MTVEC, 32'h8000_0100);
    do_inst(1, 0, 0, 2'b00, 0, 12'h000, 32'h0, 32'h8000_0010, 8'h0B);
    idle_cycle();
    // mret
    set_csr(CSR_MEPC, 32'h8000_0014);
    do_inst(0, 1, 0, 2'b00, 0, 12'h000, 32'h0, 32'h8000_0020, 8'h00);
    idle_cycle();
    // csrrs, then the same with rs1=x0
    set_csr(CSR_MSTATUS, 32'h0000_1800);
    do_inst(0, 0, 1, 2'b01, 0, CSR_MSTATUS, 32'h8, 32'h8000_0030, 8'h00);
    check_eq("csrrs_wdata", bus.csr_wdata, 32'h0000_1808);
    set_csr(CSR_MSTATUS, 32'h0000_1800);
    do_inst(0, 0, 1, 2'b01, 1, CSR_MSTATUS, 32'h0, 32'h8000_0034, 8'h00);
    // csrrc
    set_csr(CSR_MTVEC, 32'h0000_FFFF);
    do_inst(0, 0, 1, 2'b10, 0, CSR_MTVEC, 32'h0000_00F0, 32'h8000_0038, 8'h00);
    check_eq("csrrc_wdata", bus.csr_wdata, 32'h0000_FF0F);
    // csrrw
    set_csr(CSR_MTVEC, 32'h8000_0100);
    do_inst(0, 0, 1, 2'b00, 0, CSR_MTVEC, 32'h8000_0200, 32'h8000_003C, 8'h00);
    check_eq("csrrw_wdata", bus.csr_wdata, 32'h8000_0200);
    // ecall and csr together: trap path wins
    do_inst(1, 0, 1, 2'b00, 0, CSR_MSTATUS, 32'h1234_5678, 32'h8000_0040, 8'h21);

    // reset during TRAP: no trap write, no redirect, idle afterwards
    @(negedge clk);
    bus.inst_valid = 1'b1; bus.is_ecall = 1'b1; bus.is_mret = 1'b0; bus.is_csr = 1'b0;
    bus.pc = 32'h8000_0050; bus.a7 = 8'h5A;
    #1;
    check_eq("abort_acc_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ecall_en", 32'(bus.ecall_en), 32'd0);
    check_eq("abort_redir", 32'(bus.redirect_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inst_valid = 1'b0;
    #1;
    check_idle("abort_idle");
    // mepc must still hold the previous trap's pc
    do_inst(0, 1, 0, 2'b00, 0, 12'h000, 32'h0, 32'h8000_0060, 8'h00);

    for (int i = 0; i < 200; i++) begin
      e  = ($urandom_range(0, 4) == 0);
      m  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 1) == 1);
      if (!e && !m && !c) c = 1'b1;
      rz  = ($urandom_range(0, 3) == 0);
      rs1 = rz ? 32'h0 : $urandom;
      do_inst(e, m, c, 2'($urandom), rz, addr_list[$urandom_range(0, N_ADDR-1)],
              rs1, {$urandom, 2'b00} >> 0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
